// File: rtl/fpcvt_seq_if.sv
// Handshake bundle between the sample source, the converter and the float consumer.
interface fpcvt_seq_if;
    logic [11:0] d;
    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        out_valid;
    logic        out_ready;

    // Source/consumer side drives the sample and takes the result.
    modport master (
        output d, in_valid, out_ready,
        input  in_ready, s, e, f, out_valid
    );

    // Converter side.
    modport slave (
        input  d, in_valid, out_ready,
        output in_ready, s, e, f, out_valid
    );
endinterface

// File: rtl/fpcvt_seq.sv
// Multi-cycle 12-bit two's-complement to 8-bit float (s, e[2:0], f[3:0]) converter.
// Normalises one bit per cycle, then rounds on the fifth significand bit.
module fpcvt_seq #(
    parameter bit RND_EN = 1'b1
) (
    input logic        clk,
    input logic        rst,
    fpcvt_seq_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StAbs, StNorm, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [11:0] d_q, d_d;
    logic [11:0] m_q, m_d;
    logic [2:0]  ec_q, ec_d;
    logic        sign_q, sign_d;
    logic        sat_q, sat_d;
    logic        s_q, s_d;
    logic [2:0]  e_q, e_d;
    logic [3:0]  f_q, f_d;

    logic [11:0] abs_val;
    logic [3:0]  sig;
    logic        fifth;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StAbs;
            StAbs:   state_d = (d_q == 12'h800) ? StRound : StNorm;
            StNorm:  if (m_q[10] || ec_q == 3'd0) state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state; result comes straight from its registers.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.s         = s_q;
        bus.e         = e_q;
        bus.f         = f_q;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            m_q    <= '0;
            ec_q   <= '0;
            sign_q <= 1'b0;
            sat_q  <= 1'b0;
            s_q    <= 1'b0;
            e_q    <= '0;
            f_q    <= '0;
        end else begin
            d_q    <= d_d;
            m_q    <= m_d;
            ec_q   <= ec_d;
            sign_q <= sign_d;
            sat_q  <= sat_d;
            s_q    <= s_d;
            e_q    <= e_d;
            f_q    <= f_d;
        end
    end

    // Datapath next-state: capture, magnitude, shift-normalise, round.
    always_comb begin
        d_d     = d_q;
        m_d     = m_q;
        ec_d    = ec_q;
        sign_d  = sign_q;
        sat_d   = sat_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        // 0x800 negates to itself; the saturate flag covers that case.
        abs_val = d_q[11] ? (~d_q + 12'd1) : d_q;
        sig     = m_q[10:7];
        fifth   = m_q[6] & RND_EN;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) d_d = bus.d;
            end
            StAbs: begin
                sign_d = d_q[11];
                m_d    = abs_val;
                ec_d   = 3'd7;
                sat_d  = (d_q == 12'h800);
            end
            StNorm: begin
                if (!(m_q[10] || ec_q == 3'd0)) begin
                    m_d  = m_q << 1;
                    ec_d = ec_q - 3'd1;
                end
            end
            StRound: begin
                s_d = sign_q;
                if (sat_q) begin
                    f_d = 4'hF;
                    e_d = 3'd7;
                end else if (!fifth) begin
                    f_d = sig;
                    e_d = ec_q;
                end else if (sig != 4'hF) begin
                    f_d = sig + 4'd1;
                    e_d = ec_q;
                end else if (ec_q != 3'd7) begin
                    // Carry out of the significand renormalises to 1000.
                    f_d = 4'h8;
                    e_d = ec_q + 3'd1;
                end else begin
                    f_d = 4'hF;
                    e_d = 3'd7;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Directed bench for fpcvt_seq: rounding and truncating instances run in lockstep.
module tb_fpcvt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] d_drv;
    logic        in_valid_drv;
    logic        out_ready_drv;

    int n_vec = 0;
    int n_bad = 0;

    fpcvt_seq_if bus ();
    fpcvt_seq_if bus_t ();

    assign bus.d           = d_drv;
    assign bus.in_valid    = in_valid_drv;
    assign bus.out_ready   = out_ready_drv;
    assign bus_t.d         = d_drv;
    assign bus_t.in_valid  = in_valid_drv;
    assign bus_t.out_ready = out_ready_drv;

    fpcvt_seq #(.RND_EN(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fpcvt_seq #(.RND_EN(1'b0)) u_dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a sample and let the accepting edge pass.
    task automatic start(input logic [11:0] din);
        chk("in_ready_idle", {15'd0, bus.in_ready}, 16'd1);
        d_drv        = din;
        in_valid_drv = 1'b1;
        @(posedge clk);
        #1;
        in_valid_drv = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid, then check both results.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [7:0] exp_r, input logic [7:0] exp_t);
        int lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        chk({tag, "_rnd"}, {8'd0, bus.s, bus.e, bus.f}, {8'd0, exp_r});
        chk({tag, "_trunc"}, {8'd0, bus_t.s, bus_t.e, bus_t.f}, {8'd0, exp_t});
        chk({tag, "_tvalid"}, {15'd0, bus_t.out_valid}, 16'd1);
    endtask

    task automatic take(input string tag);
        out_ready_drv = 1'b1;
        @(posedge clk);
        #1;
        out_ready_drv = 1'b0;
        chk({tag, "_ovalid_drop"}, {15'd0, bus.out_valid}, 16'd0);
        chk({tag, "_iready_rise"}, {15'd0, bus.in_ready}, 16'd1);
    endtask

    task automatic convert(input string tag, input logic [11:0] din, input int exp_lat,
                           input logic [7:0] exp_r, input logic [7:0] exp_t);
        start(din);
        wait_result(tag, exp_lat, exp_r, exp_t);
        take(tag);
    endtask

    initial begin
        rst           = 1'b1;
        d_drv         = '0;
        in_valid_drv  = 1'b0;
        out_ready_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_sef", {8'd0, bus.s, bus.e, bus.f}, 16'd0);

        // {s, e, f} packed as s_eee_ffff.
        convert("zero", 12'h000, 10, 8'h00, 8'h00);
        convert("p125", 12'h07D, 7, 8'h48, 8'h3F);
        convert("m1", 12'hFFF, 10, 8'h81, 8'h81);
        convert("minneg", 12'h800, 2, 8'hFF, 8'hFF);
        convert("maxpos", 12'h7FF, 3, 8'h7F, 8'h7F);
        convert("m125", 12'hF83, 7, 8'hC8, 8'hBF);

        // Backpressure: result held while a new sample waits.
        start(12'h07D);
        wait_result("bp", 7, 8'h48, 8'h3F);
        d_drv        = 12'h123;
        in_valid_drv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
            chk("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
            chk("bp_hold", {8'd0, bus.s, bus.e, bus.f}, 16'h0048);
        end
        out_ready_drv = 1'b1;
        @(posedge clk);
        #1;
        out_ready_drv = 1'b0;
        chk("bp_release_ovalid", {15'd0, bus.out_valid}, 16'd0);
        chk("bp_release_iready", {15'd0, bus.in_ready}, 16'd1);
        @(posedge clk);
        #1;
        in_valid_drv = 1'b0;
        chk("bp_accepted", {15'd0, bus.in_ready}, 16'd0);
        wait_result("x123", 5, 8'h59, 8'h59);
        take("x123");

        // Reset during normalisation of 0x001.
        start(12'h001);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("mid_rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("mid_rst_sef", {8'd0, bus.s, bus.e, bus.f}, 16'd0);
        chk("mid_rst_sef_t", {8'd0, bus_t.s, bus_t.e, bus_t.f}, 16'd0);
        convert("p16", 12'h010, 9, 8'h18, 8'h18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpcvt_seq.md
Name: fpcvt_seq

Overview:
Multi-cycle sequencer for the 12-bit two's-complement to 8-bit float conversion (1 sign, 3-bit exponent, 4-bit significand).
It accepts one sample over a valid/ready handshake and normalises it with a one-bit-per-cycle shifter. It then rounds using the fifth significand bit, with the same carry and saturation rules as the existing combinational rounder, and holds the result until the consumer takes it.
It sits between the sample source and the float output register, replacing the single-cycle leading-zero/priority logic with a small FSM.

Parameters:
RND_EN, 1, 1 = round using the fifth bit; 0 = truncate (the fifth bit is ignored).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
d  input  12  two's-complement input sample
in_valid  input  1  d is valid
in_ready  output  1  block can accept a sample (IDLE only)
s  output  1  sign of result
e  output  3  exponent of result
f  output  4  significand of result
out_valid  output  1  s/e/f valid
out_ready  input  1  consumer takes the result

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state is updated on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, e=0, f=0, internal m=0, saturate flag=0.
- Reset mid-operation aborts the conversion; no output is produced for that sample.
- Value represented: V = f * 2^e, with s as sign.
- FSM states: IDLE, ABS, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture d, go to ABS.
- ABS:
  - s <= d[11]; m <= |d| as 12 bits; exponent counter ec <= 7.
  - If d==0x800: set the saturate flag and go to ROUND. Otherwise go to NORM.
- NORM, evaluated once per cycle:
  - If m[10]==1 or ec==0: go to ROUND.
  - Else: m <= m<<1 and ec <= ec-1.
  - k = number of shifts performed, 0..7.
- ROUND:
  - sig = m[10:7]; fifth = m[6] & RND_EN.
  - fifth==0: f=sig, e=ec.
  - fifth==1 and sig!=1111: f=sig+1, e=ec.
  - fifth==1, sig==1111 and ec<7: f=1000, e=ec+1.
  - fifth==1, sig==1111 and ec==7: saturate, f=1111, e=111.
  - Saturate flag set: f=1111, e=111.
  - Go to DONE.
- DONE:
  - out_valid=1; s/e/f are held stable.
  - On out_ready: go to IDLE. out_valid drops and in_ready rises on the next cycle.
- Latency: out_valid rises k+3 rising edges after the accepting edge, i.e. 3..10 edges. For d=0x800 it rises after 2 edges.
- Throughput: at most one sample in flight. in_ready=0 in every state except IDLE.
- in_valid/d changes outside IDLE are ignored.
- out_ready while out_valid=0 is ignored.
- s/e/f keep their last result after leaving DONE and are only updated in ROUND.
- Zero input converts to s=0, e=0, f=0000 after the full 7 shifts.

Test Plan:
- d=0x000 -> s=0 e=000 f=0000; out_valid 10 edges after accept.
- d=0x07D (125) -> 4 shifts, sig=1111, fifth=1, carry -> s=0 e=100 f=1000 (128); latency 7. With RND_EN=0 -> e=011 f=1111.
- d=0xFFF (-1) -> s=1 e=000 f=0001; latency 10.
- d=0x800 -> s=1 e=111 f=1111 via the saturate path, latency 2. d=0x7FF -> s=0 e=111 f=1111 via round saturation, latency 3.
- Backpressure: complete 0x07D, hold out_ready=0 for 5 cycles while driving in_valid=1 d=0x123. Required: s/e/f stable, in_ready=0, and 0x123 is not accepted until the cycle after out_ready.
- Assert rst for one cycle during NORM of 0x001. Required: next cycle IDLE, in_ready=1, out_valid=0, s/e/f=0; a following 0x010 converts to e=001 f=1000.
